// File: rtl/line_window_buffer_pkg.sv
// rtl/line_window_buffer_pkg.sv - default geometry constants and window tap-offset helper
package line_window_buffer_pkg;

  localparam int DEF_PIXEL_WIDTH  = 1;
  localparam int DEF_IMAGE_WIDTH  = 7;
  localparam int DEF_IMAGE_HEIGHT = 5;
  localparam int DEF_WINDOW_SIZE  = 3;
  localparam int DEF_ADDR_WIDTH   = 3;

  // Bit offset of window tap (r,c); r=0 is the oldest line, c=0 the oldest column.
  function automatic int tap_offset(input int r, input int c, input int n, input int pw);
    return (r * n + c) * pw;
  endfunction

endpackage

// File: rtl/line_window_buffer_line_store.sv
// rtl/line_window_buffer_line_store.sv - one image line of pixels, sync write / async read, no reset
module line_store #(
  parameter int PixelWidth = 1,
  parameter int Depth      = 7,
  parameter int AddrWidth  = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AddrWidth-1:0]  addr,
  input  logic [PixelWidth-1:0] wr_data,
  output logic [PixelWidth-1:0] rd_data
);

  logic [PixelWidth-1:0] line_mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_mem[addr] <= wr_data;
    end
  end

  assign rd_data = line_mem[addr];

endmodule

// File: rtl/line_window_buffer.sv
// rtl/line_window_buffer.sv - raster line buffer producing an N x N sliding pixel window
// Optional FrameDone output enabled by LINEBUF_FRAME_DONE_EN.
module line_window_buffer
  import line_window_buffer_pkg::*;
#(
  parameter int PixelWidth  = DEF_PIXEL_WIDTH,
  parameter int ImageWidth  = DEF_IMAGE_WIDTH,
  parameter int ImageHeight = DEF_IMAGE_HEIGHT,
  parameter int WindowSize  = DEF_WINDOW_SIZE,
  parameter int AddrWidth   = DEF_ADDR_WIDTH
) (
  input  logic                                           Clock,
  input  logic                                           Reset,
  input  logic                                           InValid,
  input  logic [PixelWidth-1:0]                          InData,
  input  logic                                           FrameStart,
  output logic                                           OutValid,
  output logic [WindowSize*WindowSize*PixelWidth-1:0]    Window,
  output logic [AddrWidth-1:0]                           Col,
  output logic [AddrWidth-1:0]                           Row
`ifdef LINEBUF_FRAME_DONE_EN
  ,
  output logic                                           FrameDone
`endif
);

  localparam int N       = WindowSize;
  localparam int WinBits = N * N * PixelWidth;
  localparam logic [AddrWidth-1:0] LastCol  = AddrWidth'(ImageWidth - 1);
  localparam logic [AddrWidth-1:0] LastRow  = AddrWidth'(ImageHeight - 1);
  localparam logic [AddrWidth-1:0] FirstTap = AddrWidth'(N - 1);

  logic [AddrWidth-1:0]  col_q, col_d;
  logic [AddrWidth-1:0]  row_q, row_d;
  logic [AddrWidth-1:0]  acc_col, acc_row;
  logic                  out_valid_q, out_valid_d;
  logic [WinBits-1:0]    window_q, window_d;
  logic [PixelWidth-1:0] line_rd [N-1];
  logic [PixelWidth-1:0] tap_col [N];

  // A pixel arriving with FrameStart is taken as (0,0) regardless of the counters.
  assign acc_col = FrameStart ? '0 : col_q;
  assign acc_row = FrameStart ? '0 : row_q;

  for (genvar k = 0; k < N - 1; k++) begin : g_line
    logic [PixelWidth-1:0] wr_data;
    if (k == N - 2) begin : g_newest
      assign wr_data = InData;
    end else begin : g_older
      assign wr_data = line_rd[k+1];
    end
    line_store #(
      .PixelWidth(PixelWidth),
      .Depth     (ImageWidth),
      .AddrWidth (AddrWidth)
    ) u_line (
      .clk    (Clock),
      .wr_en  (InValid),
      .addr   (acc_col),
      .wr_data(wr_data),
      .rd_data(line_rd[k])
    );
  end

  always_comb begin
    for (int k = 0; k < N - 1; k++) begin
      tap_col[k] = line_rd[k];
    end
    tap_col[N-1] = InData;
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = 1'b0;
    window_d    = window_q;
    if (InValid) begin
      out_valid_d = (acc_row >= FirstTap) && (acc_col >= FirstTap);
      if (acc_col == LastCol) begin
        col_d = '0;
        row_d = (acc_row == LastRow) ? '0 : acc_row + 1'b1;
      end else begin
        col_d = acc_col + 1'b1;
        row_d = acc_row;
      end
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          if (c < N - 1) begin
            window_d[tap_offset(r, c, N, PixelWidth) +: PixelWidth] =
              window_q[tap_offset(r, c + 1, N, PixelWidth) +: PixelWidth];
          end else begin
            window_d[tap_offset(r, c, N, PixelWidth) +: PixelWidth] = tap_col[r];
          end
        end
      end
    end else if (FrameStart) begin
      col_d = '0;
      row_d = '0;
    end
  end

`ifdef LINEBUF_FRAME_DONE_EN
  logic frame_done_q, frame_done_d;

  always_comb begin
    frame_done_d = InValid && (acc_row == LastRow) && (acc_col == LastCol);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_done_d;
    end
  end

  assign FrameDone = frame_done_q;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      window_q    <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      window_q    <= window_d;
    end
  end

  assign OutValid = out_valid_q;
  assign Window   = window_q;
  assign Col      = col_q;
  assign Row      = row_q;

endmodule
